// File: rtl/cpu.sv
// cpu: 8-bit single-cycle accumulator/register CPU for the model computer.
// The program ROM (256x8) is reloaded from a built-in image on rstROM and can
// be edited one byte at a time. Registers r0-r5, data RAM addressed by r4, PC,
// and the output port all execute one instruction per enabled clock edge.
// The image-select port is called program_sel because "program" is a
// reserved word in SystemVerilog.
module cpu (
  input  logic       clk,
  input  logic       rst,
  input  logic       rstROM,
  input  logic       NEXT,
  input  logic       RUN,
  input  logic       SPEEDRUN,
  input  logic       edit,
  input  logic [7:0] unit,
  input  logic [7:0] code,
  input  logic       send,
  input  logic [1:0] program_sel,
  input  logic [7:0] I,
  output logic [7:0] O,
  output logic       IEnable,
  output logic       OEnable,
  output logic [7:0] reg0_monitor_signal,
  output logic [7:0] reg1_monitor_signal,
  output logic [7:0] reg2_monitor_signal,
  output logic [7:0] reg3_monitor_signal,
  output logic [7:0] reg4_monitor_signal,
  output logic [7:0] reg5_monitor_signal,
  output logic [7:0] counter_monitor_signal,
  output logic [7:0] O_monitor_signal
);

  logic [7:0] rom_q [256];
  logic [7:0] ram_q [256];
  logic [7:0] reg_q [6];
  logic [7:0] reg_d [6];
  logic [7:0] pc_q, pc_d;
  logic [7:0] o_q, o_d;
  logic       run_q, run_d;
  logic       exec_en;
  logic [7:0] instr;
  logic [7:0] src_val;
  logic [7:0] alu_y;
  logic       take;
  logic       ram_we;

  // Built-in ROM images; only image 01 (RAM echo) has content.
  function automatic logic [7:0] image_byte(input logic [1:0] sel, input logic [7:0] addr);
    logic [7:0] b;
    b = 8'h00;
    if (sel == 2'b01) begin
      case (addr)
        8'd0:  b = 8'h00; 8'd1:  b = 8'h84; 8'd2:  b = 8'hB7; 8'd3:  b = 8'hA1;
        8'd4:  b = 8'h01; 8'd5:  b = 8'h82; 8'd6:  b = 8'h44; 8'd7:  b = 8'h9C;
        8'd8:  b = 8'hA1; 8'd9:  b = 8'h20; 8'd10: b = 8'h82; 8'd11: b = 8'h45;
        8'd12: b = 8'h02; 8'd13: b = 8'hC5; 8'd14: b = 8'h00; 8'd15: b = 8'h84;
        8'd16: b = 8'hBE; 8'd17: b = 8'hA1; 8'd18: b = 8'h01; 8'd19: b = 8'h82;
        8'd20: b = 8'h44; 8'd21: b = 8'h9C; 8'd22: b = 8'hA1; 8'd23: b = 8'h20;
        8'd24: b = 8'h82; 8'd25: b = 8'h45; 8'd26: b = 8'h10; 8'd27: b = 8'hC5;
        8'd28: b = 8'h1C; 8'd29: b = 8'hC4;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  assign instr   = rom_q[pc_q];
  assign exec_en = !edit && (run_q || SPEEDRUN || NEXT);
  assign IEnable = (instr[7:6] == 2'b10) && (instr[5:3] == 3'd6);
  assign OEnable = (instr[7:6] == 2'b10) && (instr[2:0] == 3'd6);

  // Copy source select: r0-r5, input port, or RAM[r4].
  always_comb begin
    src_val = 8'h00;
    case (instr[5:3])
      3'd0: src_val = reg_q[0];
      3'd1: src_val = reg_q[1];
      3'd2: src_val = reg_q[2];
      3'd3: src_val = reg_q[3];
      3'd4: src_val = reg_q[4];
      3'd5: src_val = reg_q[5];
      3'd6: src_val = I;
      default: src_val = ram_q[reg_q[4]];
    endcase
  end

  // ALU on r1/r2 and signed branch condition on r3.
  always_comb begin
    alu_y = 8'h00;
    case (instr[2:0])
      3'd0: alu_y = reg_q[1] | reg_q[2];
      3'd1: alu_y = ~(reg_q[1] & reg_q[2]);
      3'd2: alu_y = ~(reg_q[1] | reg_q[2]);
      3'd3: alu_y = reg_q[1] & reg_q[2];
      3'd4: alu_y = reg_q[1] + reg_q[2];
      3'd5: alu_y = reg_q[1] - reg_q[2];
      3'd6: alu_y = reg_q[1] ^ reg_q[2];
      default: alu_y = ~(reg_q[1] ^ reg_q[2]);
    endcase
    take = 1'b0;
    case (instr[2:0])
      3'd0: take = 1'b0;
      3'd1: take = (reg_q[3] == 8'h00);
      3'd2: take = reg_q[3][7];
      3'd3: take = reg_q[3][7] || (reg_q[3] == 8'h00);
      3'd4: take = 1'b1;
      3'd5: take = (reg_q[3] != 8'h00);
      3'd6: take = !reg_q[3][7];
      default: take = !reg_q[3][7] && (reg_q[3] != 8'h00);
    endcase
  end

  // Instruction execute: next register, PC, output and run-flag values.
  always_comb begin
    for (int k = 0; k < 6; k++) reg_d[k] = reg_q[k];
    pc_d   = pc_q;
    o_d    = o_q;
    ram_we = 1'b0;
    run_d  = run_q || RUN;
    if (exec_en) begin
      pc_d = pc_q + 8'd1;
      case (instr[7:6])
        2'b00: reg_d[0] = {2'b00, instr[5:0]};
        2'b01: reg_d[3] = alu_y;
        2'b10: begin
          case (instr[2:0])
            3'd0: reg_d[0] = src_val;
            3'd1: reg_d[1] = src_val;
            3'd2: reg_d[2] = src_val;
            3'd3: reg_d[3] = src_val;
            3'd4: reg_d[4] = src_val;
            3'd5: reg_d[5] = src_val;
            3'd6: o_d      = src_val;
            default: ram_we = 1'b1;
          endcase
        end
        default: if (take) pc_d = reg_q[0];
      endcase
    end
  end

  // CPU state registers, cleared by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 6; k++) reg_q[k] <= 8'h00;
      pc_q  <= 8'h00;
      o_q   <= 8'h00;
      run_q <= 1'b0;
    end else begin
      for (int k = 0; k < 6; k++) reg_q[k] <= reg_d[k];
      pc_q  <= pc_d;
      o_q   <= o_d;
      run_q <= run_d;
    end
  end

  // Data RAM, cleared by rst; written by copies whose destination is RAM[r4].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) ram_q[k] <= 8'h00;
    end else if (ram_we) begin
      ram_q[reg_q[4]] <= src_val;
    end
  end

  // Program ROM: image reload on rstROM, byte writes in edit mode.
  always_ff @(posedge clk or posedge rstROM) begin
    if (rstROM) begin
      for (int k = 0; k < 256; k++) rom_q[k] <= image_byte(program_sel, 8'(k));
    end else if (edit && send) begin
      rom_q[unit] <= code;
    end
  end

  assign O                      = o_q;
  assign O_monitor_signal       = o_q;
  assign counter_monitor_signal = pc_q;
  assign reg0_monitor_signal    = reg_q[0];
  assign reg1_monitor_signal    = reg_q[1];
  assign reg2_monitor_signal    = reg_q[2];
  assign reg3_monitor_signal    = reg_q[3];
  assign reg4_monitor_signal    = reg_q[4];
  assign reg5_monitor_signal    = reg_q[5];

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed, self-checking bench for the accumulator CPU.
module tb_cpu;

  logic       clk = 1'b0;
  logic       rst = 1'b0, rstROM = 1'b0, NEXT = 1'b0, RUN = 1'b0, SPEEDRUN = 1'b0;
  logic       edit = 1'b0, send = 1'b0;
  logic [7:0] unit = 8'h00, code = 8'h00, I = 8'h00;
  logic [1:0] program_sel = 2'b00;
  logic [7:0] O, r0, r1, r2, r3, r4, r5, pc, o_mon;
  logic       IEnable, OEnable;

  int n_checks = 0;
  int n_fail   = 0;

  cpu dut (
    .clk(clk), .rst(rst), .rstROM(rstROM), .NEXT(NEXT), .RUN(RUN), .SPEEDRUN(SPEEDRUN),
    .edit(edit), .unit(unit), .code(code), .send(send), .program_sel(program_sel), .I(I),
    .O(O), .IEnable(IEnable), .OEnable(OEnable),
    .reg0_monitor_signal(r0), .reg1_monitor_signal(r1), .reg2_monitor_signal(r2),
    .reg3_monitor_signal(r3), .reg4_monitor_signal(r4), .reg5_monitor_signal(r5),
    .counter_monitor_signal(pc), .O_monitor_signal(o_mon)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    logic [2:0] op;
    logic [7:0] r3;
    logic [2:0] ccc;
    logic       taken;
  } vec_t;

  vec_t       vecs [13];
  logic [7:0] img [30] = '{8'h00, 8'h84, 8'hB7, 8'hA1, 8'h01, 8'h82, 8'h44, 8'h9C, 8'hA1, 8'h20,
                           8'h82, 8'h45, 8'h02, 8'hC5, 8'h00, 8'h84, 8'hBE, 8'hA1, 8'h01, 8'h82,
                           8'h44, 8'h9C, 8'hA1, 8'h20, 8'h82, 8'h45, 8'h10, 8'hC5, 8'h1C, 8'hC4};
  logic [7:0] in_vals [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
    edit = 1'b1; unit = a; code = d; send = 1'b1;
    tick();
    send = 1'b0; edit = 1'b0;
  endtask

  task automatic pulse_run();
    RUN = 1'b1;
    tick();
    RUN = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " r0"}, r0, 0); check({tag, " r1"}, r1, 0); check({tag, " r2"}, r2, 0);
    check({tag, " r3"}, r3, 0); check({tag, " r4"}, r4, 0); check({tag, " r5"}, r5, 0);
    check({tag, " pc"}, pc, 0); check({tag, " O"}, O, 0); check({tag, " O_mon"}, o_mon, 0);
  endtask

  initial begin
    int k, j, cyc;
    logic seen;
    logic [7:0] pc_hold;
    logic [7:0] exp_pc;

    for (int n = 0; n < 32; n++) in_vals[n] = 8'(n * 7 + 3);

    //           a      b      op    r3     ccc   taken
    vecs[0]  = '{6'h2A, 6'h05, 3'd0, 8'h2F, 3'd7, 1'b1};
    vecs[1]  = '{6'h2A, 6'h05, 3'd1, 8'hFF, 3'd2, 1'b1};
    vecs[2]  = '{6'h2A, 6'h05, 3'd2, 8'hD0, 3'd6, 1'b0};
    vecs[3]  = '{6'h3C, 6'h0F, 3'd3, 8'h0C, 3'd1, 1'b0};
    vecs[4]  = '{6'h3F, 6'h3F, 3'd4, 8'h7E, 3'd3, 1'b0};
    vecs[5]  = '{6'h05, 6'h2A, 3'd5, 8'hDB, 3'd3, 1'b1};
    vecs[6]  = '{6'h15, 6'h15, 3'd6, 8'h00, 3'd1, 1'b1};
    vecs[7]  = '{6'h15, 6'h15, 3'd7, 8'hFF, 3'd5, 1'b1};
    vecs[8]  = '{6'h10, 6'h10, 3'd5, 8'h00, 3'd6, 1'b1};
    vecs[9]  = '{6'h00, 6'h00, 3'd0, 8'h00, 3'd7, 1'b0};
    vecs[10] = '{6'h01, 6'h3F, 3'd4, 8'h40, 3'd0, 1'b0};
    vecs[11] = '{6'h2A, 6'h3F, 3'd3, 8'h2A, 3'd4, 1'b1};
    vecs[12] = '{6'h3F, 6'h00, 3'd6, 8'h3F, 3'd2, 1'b0};

    // All-zero image
    #2;
    program_sel = 2'b10; rstROM = 1'b1; #2; rstROM = 1'b0;
    check("img10 rom[1]", dut.rom_q[1], 8'h00);
    check("img10 rom[29]", dut.rom_q[29], 8'h00);

    // Echo image load and reset state
    program_sel = 2'b01; rstROM = 1'b1; #2; rstROM = 1'b0;
    do_rst();
    for (int a = 0; a < 30; a++) check($sformatf("rom[%0d]", a), dut.rom_q[a], img[a]);
    check("rom[30]", dut.rom_q[30], 8'h00);
    check_all_zero("reset");
    check("ram[0] reset", dut.ram_q[0], 8'h00);

    // Run: input phase
    tick();
    check("pc idle", pc, 0);
    pulse_run();
    check("pc at run edge", pc, 0);
    tick();
    check("pc first exec", pc, 1);
    k = 0; cyc = 0; seen = 1'b0;
    while (pc != 8'd14 && cyc < 2000) begin
      if (pc == 8'd2 && !seen) begin
        check("IEnable at pc2", IEnable, 1);
        seen = 1'b1;
      end
      if (IEnable) begin
        I = (k < 32) ? in_vals[k] : 8'hEE;
        k++;
      end
      tick();
      cyc++;
    end
    check("reach pc14", pc, 14);
    check("input reads", k, 32);
    check("r4 after loop1", r4, 32);
    check("ram[0]", dut.ram_q[0], in_vals[0]);
    check("ram[31]", dut.ram_q[31], in_vals[31]);

    // Run: output phase
    j = 0; cyc = 0; seen = 1'b0;
    while (pc != 8'd28 && cyc < 2000) begin
      if (pc == 8'd16 && !seen) begin
        check("OEnable at pc16", OEnable, 1);
        seen = 1'b1;
      end
      if (OEnable) begin
        tick();
        check($sformatf("O out %0d", j), O, (j < 32) ? in_vals[j] : 8'hEE);
        check($sformatf("O_mon out %0d", j), o_mon, O);
        j++;
      end else begin
        tick();
      end
      cyc++;
    end
    check("reach pc28", pc, 28);
    check("outputs", j, 32);
    for (int n = 0; n < 4; n++) begin
      tick();
      check("halt loop pc", pc, (n % 2 == 0) ? 29 : 28);
    end

    // Edit while running
    pc_hold = pc;
    edit = 1'b1; unit = 8'd5; code = 8'h3F; send = 1'b1;
    tick();
    send = 1'b0;
    tick(); tick();
    check("pc frozen in edit", pc, pc_hold);
    check("rom[5] edited", dut.rom_q[5], 8'h3F);
    edit = 1'b0;

    // Single-step ADD then SUB
    do_rst();
    load_byte(0, 8'h2A); load_byte(1, 8'h81); load_byte(2, 8'h05);
    load_byte(3, 8'h82); load_byte(4, 8'h44);
    NEXT = 1'b1;
    repeat (5) tick();
    NEXT = 1'b0;
    check("step r1", r1, 8'h2A);
    check("step r2", r2, 8'h05);
    check("step r3 add", r3, 8'h2F);
    check("step pc", pc, 5);
    tick();
    check("step pc hold", pc, 5);
    load_byte(4, 8'h45);
    do_rst();
    NEXT = 1'b1;
    repeat (5) tick();
    NEXT = 1'b0;
    check("step r3 sub", r3, 8'h25);

    // ALU and branch table
    for (int v = 0; v < 13; v++) begin
      do_rst();
      load_byte(0, {2'b00, vecs[v].a});
      load_byte(1, 8'h81);
      load_byte(2, {2'b00, vecs[v].b});
      load_byte(3, 8'h82);
      load_byte(4, {5'b01000, vecs[v].op});
      load_byte(5, 8'h30);
      load_byte(6, {5'b11000, vecs[v].ccc});
      NEXT = 1'b1;
      repeat (7) tick();
      NEXT = 1'b0;
      exp_pc = vecs[v].taken ? 8'h30 : 8'h07;
      check($sformatf("vec%0d r3", v), r3, vecs[v].r3);
      check($sformatf("vec%0d pc", v), pc, exp_pc);
    end

    // Speed-run executes only while held
    do_rst();
    SPEEDRUN = 1'b1;
    repeat (3) tick();
    SPEEDRUN = 1'b0;
    check("speedrun pc", pc, 3);
    tick();
    check("speedrun stop", pc, 3);

    // Asynchronous reset in the middle of a run
    program_sel = 2'b01; rstROM = 1'b1; #2; rstROM = 1'b0;
    do_rst();
    pulse_run();
    k = 0;
    for (int n = 0; n < 450; n++) begin
      if (IEnable) begin
        I = in_vals[k % 32];
        k++;
      end
      tick();
    end
    check("O nonzero before rst", (O != 8'h00), 1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async rst");
    check("ram[0] async rst", dut.ram_q[0], 8'h00);
    #1;
    rst = 1'b0;
    repeat (5) tick();
    check("no run after rst", pc, 0);
    pulse_run();
    tick();
    check("rerun pc", pc, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
